robo_navegador: RTL and testbench

- Parametrised wall-following navigation controller for the maze robot; next generation of the single-wall robot FSM.
- Adds selectable followed wall (left/right), turn-direction output, configurable rubble-collection duration with retry limit, a consecutive-turn watchdog with a trapped state, explicit start command and a saturating step counter.
- Sits between the sensor front-end and the motor/arm drivers. Commands are Moore outputs decoded from the registered state.

---
 rtl/robo_navegador.sv | 219 +++++++++++++++++++++
 tb/tb_robo_navegador.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/robo_navegador.sv
// Wall-following navigation controller for the maze robot.
// Moore commands are decoded from the registered state; watchdog, rubble and step counters sit alongside.
module robo_navegador #(
  parameter int RUBBLE_CYCLES = 4,
  parameter int MAX_TRIES     = 3,
  parameter int MAX_TURNS     = 4,
  parameter int STEP_W        = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              wall_sel,
  input  logic              head,
  input  logic              side,
  input  logic              under,
  input  logic              rubble,
  output logic              avancar,
  output logic              girar,
  output logic              dir_giro,
  output logic              recolher_entulho,
  output logic              preso,
  output logic [2:0]        estado,
  output logic [STEP_W-1:0] passos
);

  localparam logic [2:0] S_STANDBY      = 3'd0;
  localparam logic [2:0] S_AVANCANDO    = 3'd1;
  localparam logic [2:0] S_ROTACIONANDO = 3'd2;
  localparam logic [2:0] S_RET_ENTULHO  = 3'd3;
  localparam logic [2:0] S_GIRO_LADO    = 3'd4;
  localparam logic [2:0] S_PRESO        = 3'd5;

  localparam int TW = $clog2(MAX_TURNS + 1);
  localparam int RW = (RUBBLE_CYCLES > 1) ? $clog2(RUBBLE_CYCLES) : 1;
  localparam int YW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  localparam logic [TW-1:0]     TURN_FULL = TW'(MAX_TURNS);
  localparam logic [RW-1:0]     RUB_LAST  = RW'(RUBBLE_CYCLES - 1);
  localparam logic [YW-1:0]     TRY_LAST  = YW'(MAX_TRIES - 1);
  localparam logic [STEP_W-1:0] STEP_MAX  = {STEP_W{1'b1}};

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic              r_wall_lat;
  logic [TW-1:0]     r_turn_cnt;
  logic [RW-1:0]     r_rub_cnt;
  logic [YW-1:0]     r_try_cnt;
  logic [STEP_W-1:0] r_passos;
  logic              w_turn_full;
  logic              w_rub_last;
  logic              w_try_last;
  logic              w_next_is_turn;
  logic              w_stay_ret;

  // Priority decision; a turn chosen with the watchdog exhausted becomes PRESO.
  function automatic logic [2:0] f_decide(
    input logic a_under,
    input logic a_rubble,
    input logic a_side,
    input logic a_head,
    input logic a_side_rule,
    input logic a_turn_full
  );
    logic [2:0] v;
    if (a_under) begin
      v = S_STANDBY;
    end else if (a_rubble) begin
      v = S_RET_ENTULHO;
    end else if (a_side_rule && !a_side) begin
      v = S_GIRO_LADO;
    end else if (a_head) begin
      v = S_ROTACIONANDO;
    end else begin
      v = S_AVANCANDO;
    end
    if ((v == S_ROTACIONANDO || v == S_GIRO_LADO) && a_turn_full) begin
      v = S_PRESO;
    end else begin
      v = v;
    end
    return v;
  endfunction

  assign w_turn_full    = (r_turn_cnt >= TURN_FULL);
  assign w_rub_last     = (r_rub_cnt == RUB_LAST);
  assign w_try_last     = (r_try_cnt == TRY_LAST);
  assign w_next_is_turn = (w_next == S_ROTACIONANDO) || (w_next == S_GIRO_LADO);
  assign w_stay_ret     = (r_state == S_RET_ENTULHO) && (w_next == S_RET_ENTULHO);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_STANDBY;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; the side rule is only honoured while advancing.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_STANDBY: begin
        if (start) begin
          w_next = f_decide(under, rubble, side, head, 1'b0, w_turn_full);
        end else begin
          w_next = S_STANDBY;
        end
      end
      S_AVANCANDO: begin
        w_next = f_decide(under, rubble, side, head, 1'b1, w_turn_full);
      end
      S_ROTACIONANDO, S_GIRO_LADO: begin
        w_next = f_decide(under, rubble, side, head, 1'b0, w_turn_full);
      end
      S_RET_ENTULHO: begin
        if (under) begin
          w_next = S_STANDBY;
        end else if (!w_rub_last) begin
          w_next = S_RET_ENTULHO;
        end else if (!rubble) begin
          w_next = f_decide(under, rubble, side, head, 1'b0, w_turn_full);
        end else if (w_try_last) begin
          w_next = S_PRESO;
        end else begin
          w_next = S_RET_ENTULHO;
        end
      end
      S_PRESO: begin
        if (start) begin
          w_next = S_STANDBY;
        end else begin
          w_next = S_PRESO;
        end
      end
      default: begin
        w_next = S_STANDBY;
      end
    endcase
  end

  // Watchdog, rubble timers, latched wall side and saturating step counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wall_lat <= 1'b0;
      r_turn_cnt <= '0;
      r_rub_cnt  <= '0;
      r_try_cnt  <= '0;
      r_passos   <= '0;
    end else begin
      if (r_state == S_STANDBY && start) begin
        r_wall_lat <= wall_sel;
      end else begin
        r_wall_lat <= r_wall_lat;
      end

      if (w_next_is_turn) begin
        r_turn_cnt <= r_turn_cnt + TW'(1);
      end else if (w_next == S_AVANCANDO || w_next == S_STANDBY) begin
        r_turn_cnt <= '0;
      end else begin
        r_turn_cnt <= r_turn_cnt;
      end

      // Timers run only while staying in collection; any entry starts from zero.
      if (w_stay_ret && w_rub_last) begin
        r_rub_cnt <= '0;
        r_try_cnt <= r_try_cnt + YW'(1);
      end else if (w_stay_ret) begin
        r_rub_cnt <= r_rub_cnt + RW'(1);
        r_try_cnt <= r_try_cnt;
      end else begin
        r_rub_cnt <= '0;
        r_try_cnt <= '0;
      end

      if (r_state == S_AVANCANDO && r_passos != STEP_MAX) begin
        r_passos <= r_passos + STEP_W'(1);
      end else begin
        r_passos <= r_passos;
      end
    end
  end

  // Moore command decode.
  always_comb begin
    avancar          = 1'b0;
    girar            = 1'b0;
    dir_giro         = 1'b0;
    recolher_entulho = 1'b0;
    preso            = 1'b0;
    case (r_state)
      S_AVANCANDO: begin
        avancar = 1'b1;
      end
      S_ROTACIONANDO: begin
        girar    = 1'b1;
        dir_giro = ~r_wall_lat;
      end
      S_GIRO_LADO: begin
        girar    = 1'b1;
        dir_giro = r_wall_lat;
      end
      S_RET_ENTULHO: begin
        recolher_entulho = 1'b1;
      end
      S_PRESO: begin
        preso = 1'b1;
      end
      default: begin
        avancar = 1'b0;
      end
    endcase
  end

  assign estado = r_state;
  assign passos = r_passos;

endmodule

// File: tb/tb_robo_navegador.sv
// Self-checking bench: directed vector table, random stimulus against a behavioural model,
// and hand sequences for asynchronous reset and step-counter saturation.
module tb_robo_navegador;

  localparam int RC    = 4;
  localparam int MT    = 3;
  localparam int MTURN = 4;

  logic clock = 1'b0;
  logic reset, start, wall_sel, head, side, under, rubble;
  logic a_av, a_gi, a_dg, a_rc, a_pr;
  logic [2:0] a_est;
  logic [7:0] a_pas;
  logic b_av, b_gi, b_dg, b_rc, b_pr;
  logic [2:0] b_est;
  logic [1:0] b_pas;

  robo_navegador #(.RUBBLE_CYCLES(RC), .MAX_TRIES(MT), .MAX_TURNS(MTURN), .STEP_W(8)) u_dut (
    .clock(clock), .reset(reset), .start(start), .wall_sel(wall_sel), .head(head),
    .side(side), .under(under), .rubble(rubble), .avancar(a_av), .girar(a_gi),
    .dir_giro(a_dg), .recolher_entulho(a_rc), .preso(a_pr), .estado(a_est), .passos(a_pas)
  );

  robo_navegador #(.RUBBLE_CYCLES(RC), .MAX_TRIES(MT), .MAX_TURNS(MTURN), .STEP_W(2)) u_sat (
    .clock(clock), .reset(reset), .start(start), .wall_sel(wall_sel), .head(head),
    .side(side), .under(under), .rubble(rubble), .avancar(b_av), .girar(b_gi),
    .dir_giro(b_dg), .recolher_entulho(b_rc), .preso(b_pr), .estado(b_est), .passos(b_pas)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: state number, latched wall, steps, consecutive turns, cycles spent collecting.
  int m_st, m_lat, m_pas, m_pas2, m_turns, m_coll;

  typedef struct {
    bit st, ws, hd, sd, un, rb;
    int e_est;
    bit e_dir;
    int e_pas;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(input bit st, input bit ws, input bit hd, input bit sd,
                              input bit un, input bit rb, input int e_est, input bit e_dir,
                              input int e_pas);
    vec_t v;
    v.st = st; v.ws = ws; v.hd = hd; v.sd = sd; v.un = un; v.rb = rb;
    v.e_est = e_est; v.e_dir = e_dir; v.e_pas = e_pas;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int pick(input bit side_rule);
    int v;
    if (under) v = 0;
    else if (rubble) v = 3;
    else if (side_rule && !side) v = 4;
    else if (head) v = 2;
    else v = 1;
    if ((v == 2 || v == 4) && m_turns >= MTURN) v = 5;
    return v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_lat = 0; m_pas = 0; m_pas2 = 0; m_turns = 0; m_coll = 0;
  endtask

  task automatic model_step();
    int nx;
    nx = m_st;
    case (m_st)
      0: if (start) begin m_lat = wall_sel; nx = pick(1'b0); end
      1: nx = pick(1'b1);
      2, 4: nx = pick(1'b0);
      3: begin
        if (under) nx = 0;
        else if ((m_coll % RC) != RC - 1) nx = 3;
        else if (!rubble) nx = pick(1'b0);
        else if ((m_coll / RC) == MT - 1) nx = 5;
        else nx = 3;
      end
      5: if (start) nx = 0;
      default: nx = 0;
    endcase
    if (m_st == 1) begin
      if (m_pas < 255) m_pas++;
      if (m_pas2 < 3) m_pas2++;
    end
    if (nx == 2 || nx == 4) m_turns++;
    else if (nx == 0 || nx == 1) m_turns = 0;
    m_coll = (m_st == 3 && nx == 3) ? m_coll + 1 : 0;
    m_st = nx;
  endtask

  task automatic check_model();
    int exp_cmd, act_cmd, dg;
    dg = (m_st == 2) ? (1 - m_lat) : (m_st == 4) ? m_lat : 0;
    exp_cmd = (m_st << 5) | (int'(m_st == 1) << 4) | (int'(m_st == 2 || m_st == 4) << 3)
            | (dg << 2) | (int'(m_st == 3) << 1) | int'(m_st == 5);
    act_cmd = int'({a_est, a_av, a_gi, a_dg, a_rc, a_pr});
    check("model_cmd", act_cmd, exp_cmd);
    check("model_passos", int'(a_pas), m_pas);
    check("model_passos_sat", int'(b_pas), m_pas2);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_model();
  endtask

  task automatic set_in(input bit st, input bit ws, input bit hd, input bit sd,
                        input bit un, input bit rb);
    start = st; wall_sel = ws; head = hd; side = sd; under = un; rubble = rb;
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("reset_cmd", int'({a_est, a_av, a_gi, a_dg, a_rc, a_pr}), 0);
    check("reset_passos", int'(a_pas), 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int i = 1; i <= 5; i++) vt.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, i));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 4, 0, 6));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 6));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 7));
    vt.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 8));
    vt.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 8));
    vt.push_back(mk(0, 1, 0, 0, 0, 0, 4, 1, 9));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 9));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 4, 1, 10));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 10));
    vt.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 11));
    vt.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 11));
    for (int i = 0; i < 4; i++) vt.push_back(mk(0, 0, 1, 1, 0, 0, 2, 1, 12));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 5, 0, 12));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 5, 0, 12));
    vt.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 12));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 12));
    vt.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 12));
    vt.push_back(mk(0, 0, 0, 1, 0, 1, 3, 0, 13));
    vt.push_back(mk(0, 0, 0, 1, 0, 1, 3, 0, 13));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 3, 0, 13));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 3, 0, 13));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 13));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 14));
    for (int i = 0; i < 12; i++) vt.push_back(mk(0, 0, 0, 1, 0, 1, 3, 0, 15));
    vt.push_back(mk(0, 0, 0, 1, 0, 1, 5, 0, 15));
    vt.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 15));
    vt.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 15));
    vt.push_back(mk(0, 0, 0, 1, 0, 1, 3, 0, 16));
    vt.push_back(mk(0, 0, 0, 1, 0, 1, 3, 0, 16));
    vt.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 16));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 16));
    vt.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0, 16));
    vt.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 16));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 17));
    vt.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0, 18));

    foreach (vt[i]) begin
      set_in(vt[i].st, vt[i].ws, vt[i].hd, vt[i].sd, vt[i].un, vt[i].rb);
      tick();
      check($sformatf("tbl_estado[%0d]", i), int'(a_est), vt[i].e_est);
      check($sformatf("tbl_dir[%0d]", i), int'(a_dg), int'(vt[i].e_dir));
      check($sformatf("tbl_passos[%0d]", i), int'(a_pas), vt[i].e_pas);
    end

    // Random traffic; rubble pressure alternates so collection retries and PRESO get exercised.
    for (int blk = 0; blk < 20; blk++) begin
      for (int c = 0; c < 150; c++) begin
        int rb_pct;
        rb_pct = (blk % 2 == 1) ? 70 : 12;
        set_in(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)),
               bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 3) != 0),
               bit'($urandom_range(0, 24) == 0), bit'($urandom_range(0, 99) < rb_pct));
        tick();
      end
    end

    // Asynchronous reset mid-AVANCANDO, with the narrow counter already saturated.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    set_in(1, 0, 0, 1, 0, 0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("pre_reset_passos", int'(a_pas), 7);
    check("pre_reset_sat", int'(b_pas), 3);
    check("pre_reset_avancar", int'(a_av), 1);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_cmd", int'({a_est, a_av, a_gi, a_dg, a_rc, a_pr}), 0);
    check("async_reset_passos", int'(a_pas), 0);
    check("async_reset_sat", int'(b_pas), 0);
    #10;
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
